mat_mult_sched: RTL and testbench
=================================

# mat_mult_sched

Two-requester job scheduler for the 16x49 by 49x32 matrix-multiply engine. Accepts jobs of the form base_a, base_b and base_c, and arbitrates between two requesters round-robin. It sequences the engine through start/done and relocates the engine's local A, B and C addresses into larger shared memories. A watchdog aborts hung jobs and reports an error to the owning requester.

## Interface
- A_AW, 12: shared A-memory address width.
- B_AW, 13: shared B-memory address width.
- C_AW, 11: shared C-memory address width.
- TIMEOUT, 20000: maximum RUN cycles before abort. Must satisfy 1 ≤ TIMEOUT ≤ 65535.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req0_valid, req1_valid  in  1  job request. Must be held, with its bases stable, until the matching ready is seen.
- req0_base_a, req1_base_a  in  A_AW  A matrix base word address.
- req0_base_b, req1_base_b  in  B_AW  B matrix base word address.
- req0_base_c, req1_base_c  in  C_AW  C matrix base word address.
- req0_ready, req1_ready  out  1  combinational accept strobe.
- done0, done1  out  1  1-cycle registered completion pulse.
- err0, err1  out  1  1-cycle registered timeout pulse. Coincides with the doneN pulse.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  owner of the current or most recent job.
- jobs_done  out  16  count of successfully completed jobs. Saturates at 0xFFFF.
- mm_start  out  1  1-cycle registered start to the engine.
- mm_done  in  1  engine completion pulse.
- mm_soft_reset  out  1  registered reset to the engine. Used only on abort.
- mm_addr_a  in  10  engine local A address.
- mm_addr_b  in  11  engine local B address.
- mm_addr_c  in  9  engine local C address.
- mm_we_c  in  1  engine C write enable.
- mm_data_c  in  32  engine C write data.
- mem_addr_a  out  A_AW  shared A-memory address.
- mem_addr_b  out  B_AW  shared B-memory address.
- mem_addr_c  out  C_AW  shared C-memory address.
- mem_we_c  out  1  shared C-memory write enable.
- mem_data_c  out  32  shared C-memory write data.

## Operation
- States: IDLE, START, RUN, FLUSH, RESP.
- IDLE, arbitration:
  - If exactly one reqN_valid is high, that requester wins.
  - If both are high, the requester other than last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- IDLE, accept:
  - reqN_ready = (state==IDLE) & winner.
  - On the accept cycle: latch the three bases, set grant_id and last_grant, go to START.
- START: mm_start=1 for this cycle only; clear the watchdog counter; go to RUN.
- RUN: count cycles.
  - If mm_done=1, go to RESP with success.
  - Else if count == TIMEOUT-1, go to FLUSH.
  - If mm_done and the timeout occur in the same cycle, mm_done wins.
- FLUSH: exactly 2 cycles with mm_soft_reset=1, then go to RESP with error.
- RESP (1 cycle):
  - done[grant_id]=1.
  - err[grant_id]=1 only when the job aborted.
  - On success only, jobs_done increments, saturating.
  - Then go to IDLE.
- Address translation is combinational, modulo 2^width, with no overflow flag:
  - mem_addr_a = base_a + zero-extended mm_addr_a.
  - mem_addr_b = base_b + zero-extended mm_addr_b.
  - mem_addr_c = base_c + zero-extended mm_addr_c.
- Write path:
  - mem_we_c = mm_we_c & (state==RUN).
  - mem_data_c = mm_data_c, passed through.
- mm_done outside RUN is ignored.
- reqN_valid outside IDLE is ignored; ready stays 0.

## Timing
- Reset values:
  - All registered outputs are 0: done, err, mm_start, mm_soft_reset, jobs_done, grant_id.
  - Latched bases are 0.
  - State is IDLE.
  - busy is 0.
  - mem_addr_* equal the raw mm_addr_*.
  - mem_we_c is 0.
- Job lifecycle, with the accept cycle at T:
  - mm_start is high in cycle T+1.
  - RUN starts at T+2.
- Success, with mm_done sampled high in cycle D:
  - doneN is high in D+1.
  - IDLE is reached in D+2; a new accept is possible in D+2.
- Abort:
  - The last RUN cycle is T+1+TIMEOUT.
  - FLUSH occupies the next 2 cycles.
  - doneN and errN are high in the following cycle.
- Back-to-back jobs: per-job overhead outside engine time is 3 cycles (START, RESP, IDLE accept).
- Reset mid-job: return to IDLE immediately. No done or err is issued, and the job is lost. The system reset also resets the engine.
- A requester may raise valid again in the same cycle its done pulse is seen. It is considered in the next IDLE cycle.

## Test plan
- Single job, requester 0:
  - Stimulus: bases (100, 200, 50); behavioural engine with mm_done 40 cycles after start. The engine writes mm_addr_c=511, data 0x12345678.
  - Response: mem_addr_c=561 with mem_we_c=1 and data 0x12345678. done0 exactly 1 cycle; jobs_done=1.
- Tie arbitration: both valid continuously from reset. Grants must be 0,1,0,1. Each doneN must match the granted ID.
- Wrap-around: req1_base_a=4095 and mm_addr_a=3 must give mem_addr_a=2. Likewise base_b=8191 with mm_addr_b=1 must give mem_addr_b=0.
- Timeout, with TIMEOUT=16 and mm_done never asserted:
  - mm_soft_reset must be high for exactly 2 cycles starting at T+18.
  - done0 and err0 must pulse together at T+20; jobs_done is unchanged.
  - mem_we_c must stay 0 during FLUSH.
- Coincident done and timeout: mm_done in the final RUN cycle gives done without err, and no FLUSH.
- Mid-job reset: reset asserted during RUN:
  - All outputs return to their reset values.
  - No doneN is produced.
  - A subsequent request from requester 1 is accepted in the first IDLE cycle after reset release.

Source files
------------

// File: rtl/mat_mult_sched.sv
// mat_mult_sched: round-robin two-requester job scheduler for the 16x49x32 matrix-multiply engine.
// Sequences the engine through start/done, relocates engine-local A/B/C addresses into shared memories,
// and aborts hung jobs with a watchdog, reporting done+err to the owning requester.
module mat_mult_sched #(
  parameter int A_AW    = 12,
  parameter int B_AW    = 13,
  parameter int C_AW    = 11,
  parameter int TIMEOUT = 20000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [A_AW-1:0] req0_base_a,
  input  logic [B_AW-1:0] req0_base_b,
  input  logic [C_AW-1:0] req0_base_c,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [A_AW-1:0] req1_base_a,
  input  logic [B_AW-1:0] req1_base_b,
  input  logic [C_AW-1:0] req1_base_c,
  output logic            req1_ready,
  output logic            done0,
  output logic            done1,
  output logic            err0,
  output logic            err1,
  output logic            busy,
  output logic            grant_id,
  output logic [15:0]     jobs_done,
  output logic            mm_start,
  input  logic            mm_done,
  output logic            mm_soft_reset,
  input  logic [9:0]      mm_addr_a,
  input  logic [10:0]     mm_addr_b,
  input  logic [8:0]      mm_addr_c,
  input  logic            mm_we_c,
  input  logic [31:0]     mm_data_c,
  output logic [A_AW-1:0] mem_addr_a,
  output logic [B_AW-1:0] mem_addr_b,
  output logic [C_AW-1:0] mem_addr_c,
  output logic            mem_we_c,
  output logic [31:0]     mem_data_c
);

  typedef enum logic [2:0] {IDLE, START, RUN, FLUSH, RESP} state_t;

  // Watchdog terminal count: RUN lasts at most TIMEOUT cycles (count 0..TIMEOUT-1).
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t          state;
  logic            last_grant;
  logic [A_AW-1:0] base_a_q;
  logic [B_AW-1:0] base_b_q;
  logic [C_AW-1:0] base_c_q;
  logic [15:0]     wd_cnt;
  logic            flush_cnt;
  logic            win0;
  logic            win1;

  // Round-robin winner: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    win0 = req0_valid & (~req1_valid | last_grant);
    win1 = req1_valid & (~req0_valid | ~last_grant);
  end

  assign req0_ready = (state == IDLE) & win0;
  assign req1_ready = (state == IDLE) & win1;
  assign busy       = (state != IDLE);

  // Relocation into shared memories; wraps modulo the shared address width.
  assign mem_addr_a = base_a_q + A_AW'(mm_addr_a);
  assign mem_addr_b = base_b_q + B_AW'(mm_addr_b);
  assign mem_addr_c = base_c_q + C_AW'(mm_addr_c);
  assign mem_we_c   = mm_we_c & (state == RUN);
  assign mem_data_c = mm_data_c;

  // Job sequencer: accept, start pulse, watchdog-guarded run, 2-cycle engine flush, response pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      base_a_q      <= '0;
      base_b_q      <= '0;
      base_c_q      <= '0;
      wd_cnt        <= '0;
      flush_cnt     <= 1'b0;
      mm_start      <= 1'b0;
      mm_soft_reset <= 1'b0;
      done0         <= 1'b0;
      done1         <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;
      jobs_done     <= '0;
    end else begin
      mm_start <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      case (state)
        IDLE: begin
          if (win0 | win1) begin
            base_a_q   <= win1 ? req1_base_a : req0_base_a;
            base_b_q   <= win1 ? req1_base_b : req0_base_b;
            base_c_q   <= win1 ? req1_base_c : req0_base_c;
            grant_id   <= win1;
            last_grant <= win1;
            mm_start   <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= RUN;
        end
        RUN: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (mm_done) begin
            done0 <= ~grant_id;
            done1 <= grant_id;
            state <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            mm_soft_reset <= 1'b1;
            flush_cnt     <= 1'b0;
            state         <= FLUSH;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt) begin
            mm_soft_reset <= 1'b0;
            done0         <= ~grant_id;
            done1         <= grant_id;
            err0          <= ~grant_id;
            err1          <= grant_id;
            state         <= RESP;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        RESP: begin
          // err pulses are high during RESP exactly when the job was aborted.
          if (!(err0 | err1) && jobs_done != 16'hFFFF)
            jobs_done <= jobs_done + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_sched.sv
// Self-checking bench for mat_mult_sched: table-driven job vectors plus
// hand-written tie-arbitration, watchdog-abort and mid-job-reset sequences.
module tb_mat_mult_sched;

  localparam int TO = 48;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [11:0] req0_base_a, req1_base_a;
  logic [12:0] req0_base_b, req1_base_b;
  logic [10:0] req0_base_c, req1_base_c;
  logic        req0_ready, req1_ready;
  logic        done0, done1, err0, err1, busy, grant_id;
  logic [15:0] jobs_done;
  logic        mm_start, mm_done, mm_soft_reset;
  logic [9:0]  mm_addr_a;
  logic [10:0] mm_addr_b;
  logic [8:0]  mm_addr_c;
  logic        mm_we_c;
  logic [31:0] mm_data_c;
  logic [11:0] mem_addr_a;
  logic [12:0] mem_addr_b;
  logic [10:0] mem_addr_c;
  logic        mem_we_c;
  logic [31:0] mem_data_c;

  int checks   = 0;
  int failures = 0;
  int exp_jobs = 0;

  mat_mult_sched #(.A_AW(12), .B_AW(13), .C_AW(11), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_base_a(req0_base_a), .req0_base_b(req0_base_b),
    .req0_base_c(req0_base_c), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_base_a(req1_base_a), .req1_base_b(req1_base_b),
    .req1_base_c(req1_base_c), .req1_ready(req1_ready),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .busy(busy), .grant_id(grant_id), .jobs_done(jobs_done),
    .mm_start(mm_start), .mm_done(mm_done), .mm_soft_reset(mm_soft_reset),
    .mm_addr_a(mm_addr_a), .mm_addr_b(mm_addr_b), .mm_addr_c(mm_addr_c),
    .mm_we_c(mm_we_c), .mm_data_c(mm_data_c),
    .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b), .mem_addr_c(mem_addr_c),
    .mem_we_c(mem_we_c), .mem_data_c(mem_data_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v0, v1;
    logic [11:0] a0; logic [12:0] b0; logic [10:0] c0;
    logic [11:0] a1; logic [12:0] b1; logic [10:0] c1;
    logic [9:0]  ma; logic [10:0] mb; logic [8:0] mc;
    logic [31:0] dat;
    int          run_cyc;
    logic        g;
    logic [11:0] ea; logic [12:0] eb; logic [10:0] ec;
  } vec_t;

  vec_t vt[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_base_a = '0; req0_base_b = '0; req0_base_c = '0;
    req1_base_a = '0; req1_base_b = '0; req1_base_c = '0;
    mm_done = 1'b0; mm_we_c = 1'b0; mm_data_c = '0;
    mm_addr_a = '0; mm_addr_b = '0; mm_addr_c = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    exp_jobs = 0;
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 12'd100, 13'd200, 11'd50, 12'd0, 13'd0, 11'd0,
              10'd7, 11'd9, 9'd511, 32'h12345678, 40, 1'b0, 12'd107, 13'd209, 11'd561};
    vt[1] = '{1'b0, 1'b1, 12'd0, 13'd0, 11'd0, 12'd4095, 13'd8191, 11'd2040,
              10'd3, 11'd1, 9'd10, 32'hDEADBEEF, 5, 1'b1, 12'd2, 13'd0, 11'd2};
    vt[2] = '{1'b1, 1'b1, 12'd1000, 13'd3000, 11'd0, 12'd77, 13'd77, 11'd77,
              10'd1023, 11'd2047, 9'd0, 32'h00000000, 1, 1'b0, 12'd2023, 13'd5047, 11'd0};
    vt[3] = '{1'b1, 1'b1, 12'd5, 13'd5, 11'd5, 12'd0, 13'd0, 11'd1500,
              10'd5, 11'd6, 9'd300, 32'hA5A5A5A5, TO, 1'b1, 12'd5, 13'd6, 11'd1800};
    vt[4] = '{1'b1, 1'b0, 12'd2048, 13'd4096, 11'd1024, 12'd0, 13'd0, 11'd0,
              10'd512, 11'd1024, 9'd256, 32'h00000001, 2, 1'b0, 12'd2560, 13'd5120, 11'd1280};

    // Reset state
    reset = 1'b1;
    clear_inputs();
    mm_addr_a = 10'd21; mm_addr_b = 11'd33; mm_addr_c = 9'd45; mm_we_c = 1'b1;
    #3;
    chk("rst_done", {done0, done1, err0, err1}, 0);
    chk("rst_start_soft", {mm_start, mm_soft_reset}, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_a", mem_addr_a, 21);
    chk("rst_addr_b", mem_addr_b, 33);
    chk("rst_addr_c", mem_addr_c, 45);
    chk("rst_we", mem_we_c, 0);
    do_reset();

    // Table-driven jobs: arbitration, translation, completion, counting
    for (int i = 0; i < 5; i++) begin
      req0_valid = vt[i].v0; req1_valid = vt[i].v1;
      req0_base_a = vt[i].a0; req0_base_b = vt[i].b0; req0_base_c = vt[i].c0;
      req1_base_a = vt[i].a1; req1_base_b = vt[i].b1; req1_base_c = vt[i].c1;
      #1;
      chk("tbl_ready0", req0_ready, {31'd0, ~vt[i].g});
      chk("tbl_ready1", req1_ready, {31'd0, vt[i].g});
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("tbl_start", mm_start, 1);
      chk("tbl_grant", grant_id, {31'd0, vt[i].g});
      chk("tbl_busy", busy, 1);
      tick();
      chk("tbl_start_end", mm_start, 0);
      mm_addr_a = vt[i].ma; mm_addr_b = vt[i].mb; mm_addr_c = vt[i].mc;
      mm_data_c = vt[i].dat; mm_we_c = 1'b1;
      #1;
      chk("tbl_mem_a", mem_addr_a, {20'd0, vt[i].ea});
      chk("tbl_mem_b", mem_addr_b, {19'd0, vt[i].eb});
      chk("tbl_mem_c", mem_addr_c, {21'd0, vt[i].ec});
      chk("tbl_we", mem_we_c, 1);
      chk("tbl_data", mem_data_c, vt[i].dat);
      for (int k = 1; k < vt[i].run_cyc; k++) begin
        tick();
        chk("tbl_no_early_done", {done0, done1, mm_soft_reset}, 0);
      end
      mm_done = 1'b1;
      tick();
      mm_done = 1'b0; mm_we_c = 1'b0;
      exp_jobs++;
      chk("tbl_done0", done0, {31'd0, ~vt[i].g});
      chk("tbl_done1", done1, {31'd0, vt[i].g});
      chk("tbl_err", {err0, err1, mm_soft_reset}, 0);
      tick();
      chk("tbl_done_1cyc", {done0, done1}, 0);
      chk("tbl_idle", busy, 0);
      chk("tbl_jobs", jobs_done, exp_jobs);
    end

    // Tie arbitration: both requesters valid continuously from reset
    reset = 1'b1;
    clear_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2 == 1);
      #1;
      chk("tie_ready0", req0_ready, {31'd0, ~g});
      chk("tie_ready1", req1_ready, {31'd0, g});
      tick();
      chk("tie_grant", grant_id, {31'd0, g});
      tick();
      tick();
      mm_done = 1'b1;
      tick();
      mm_done = 1'b0;
      chk("tie_done0", done0, {31'd0, ~g});
      chk("tie_done1", done1, {31'd0, g});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Watchdog abort, accept at cycle T (n counts cycles since T)
    do_reset();
    mm_we_c = 1'b1; mm_data_c = 32'hCAFE0000;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    for (int n = 2; n <= TO + 5; n++) begin
      tick();
      chk("to_we", mem_we_c, (n <= TO + 1) ? 1 : 0);
      chk("to_soft", mm_soft_reset, (n == TO + 2 || n == TO + 3) ? 1 : 0);
      chk("to_done0", done0, (n == TO + 4) ? 1 : 0);
      chk("to_err0", err0, (n == TO + 4) ? 1 : 0);
      chk("to_busy", busy, (n <= TO + 4) ? 1 : 0);
    end
    chk("to_side1", {done1, err1}, 0);
    chk("to_jobs", jobs_done, 0);
    mm_we_c = 1'b0;

    // Mid-job reset during RUN
    req0_valid = 1'b1;
    req0_base_a = 12'd300;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_busy_pre", busy, 1);
    mm_addr_a = 10'd10; mm_we_c = 1'b1;
    reset = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_regs", {done0, done1, err0, err1, mm_start, mm_soft_reset, grant_id}, 0);
    chk("mr_jobs", jobs_done, 0);
    chk("mr_addr_a", mem_addr_a, 10);
    chk("mr_we", mem_we_c, 0);
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    chk("mr_no_done", {done0, done1}, 0);
    reset = 1'b0;
    mm_we_c = 1'b0;
    req1_valid = 1'b1;
    #1;
    chk("mr_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("mr_grant", grant_id, 1);
    chk("mr_start", mm_start, 1);
    chk("mr_no_done2", {done0, done1}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
